// File: rtl/mtr_drv.sv
// mtr_drv -- wheel motor driver for the left and right H-bridges.
// Each signed speed word is saturated and offset into an 11-bit duty.
// The duty drives a shared 2048-clock PWM period. Each side produces a
// complementary, dead-time separated high/low gate pair.
// Optional overcurrent blanking, period counting and latched shutdown are
// compiled in when the macro MTR_OVR_I_PROT_EN is defined. Otherwise the
// OVR_I_* inputs are ignored and OVR_I_shtdwn is tied low.
module mtr_drv #(
    parameter int NONOVERLAP = 32,
    parameter int BLANK      = 128,
    parameter int OVR_LIMIT  = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [11:0] lft_spd,
    input  logic signed [11:0] rght_spd,
    input  logic               OVR_I_lft,
    input  logic               OVR_I_rght,
    output logic               PWM1_lft,
    output logic               PWM2_lft,
    output logic               PWM1_rght,
    output logic               PWM2_rght,
    output logic               OVR_I_shtdwn
);

    // The run counter only has to tell whether it is past the blank window,
    // so it saturates one count above that point.
    localparam int RUN_MAX = NONOVERLAP + BLANK + 1;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);

    localparam logic [RUN_W-1:0] RUN_SAT  = RUN_W'(RUN_MAX);
    localparam logic [RUN_W-1:0] DEAD_THR = RUN_W'(NONOVERLAP);
    localparam logic [10:0]      CNT_LAST = 11'h7FF;
    localparam logic [10:0]      DUTY_MID = 11'd1024;

    // Index 0 is the left side and index 1 is the right side throughout.

    // Clip the speed to -1024..1023, then shift it into the unsigned range 0..2047.
    function automatic logic [10:0] spd_to_duty(input logic signed [11:0] spd);
        logic signed [11:0] clipped;
        logic signed [11:0] biased;
        if (spd > 12'sd1023) begin
            clipped = 12'sd1023;
        end else if (spd < -12'sd1024) begin
            clipped = -12'sd1024;
        end else begin
            clipped = spd;
        end
        biased = clipped + 12'sd1024;
        return biased[10:0];
    endfunction

    logic [10:0]           cnt_q, cnt_d;
    logic [1:0][10:0]      duty_q, duty_d, duty_new;
    logic [1:0]            pwm_sig_q, pwm_sig_d;
    logic [1:0][RUN_W-1:0] run_q, run_d;
    logic [1:0]            pwm1_q, pwm1_d;
    logic [1:0]            pwm2_q, pwm2_d;
    logic                  shtdwn_d;

    assign duty_new[0] = spd_to_duty(lft_spd);
    assign duty_new[1] = spd_to_duty(rght_spd);

    // Period counter, duty double-buffer, raw PWM, run length and dead-time legs.
    always_comb begin
        cnt_d     = cnt_q + 11'd1;
        duty_d    = duty_q;
        pwm_sig_d = '0;
        run_d     = run_q;
        pwm1_d    = '0;
        pwm2_d    = '0;
        for (int s = 0; s < 2; s++) begin
            // A new duty is taken only at the period boundary, so a period
            // is never cut short or stretched by a mid-period speed change.
            if (cnt_q == CNT_LAST) begin
                duty_d[s] = duty_new[s];
            end
            pwm_sig_d[s] = (cnt_q < duty_q[s]);
            // run_q counts the clocks since the last pwm_sig edge, minus one.
            if (pwm_sig_d[s] != pwm_sig_q[s]) begin
                run_d[s] = '0;
            end else if (run_q[s] != RUN_SAT) begin
                run_d[s] = run_q[s] + RUN_W'(1);
            end
            // A leg turns on only once pwm_sig has held its level for more
            // than NONOVERLAP clocks. Both legs therefore stay low through
            // every dead band, and a run that is too short yields no pulse.
            pwm1_d[s] = pwm_sig_q[s]  & (run_q[s] >= DEAD_THR) & ~shtdwn_d;
            pwm2_d[s] = ~pwm_sig_q[s] & (run_q[s] >= DEAD_THR) & ~shtdwn_d;
        end
    end

    // Core state. The gate drives are flops so that they cannot glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            duty_q    <= {DUTY_MID, DUTY_MID};
            pwm_sig_q <= '0;
            run_q     <= '0;
            pwm1_q    <= '0;
            pwm2_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            duty_q    <= duty_d;
            pwm_sig_q <= pwm_sig_d;
            run_q     <= run_d;
            pwm1_q    <= pwm1_d;
            pwm2_q    <= pwm2_d;
        end
    end

`ifdef MTR_OVR_I_PROT_EN
    localparam logic [RUN_W-1:0] BLANK_THR = RUN_W'(NONOVERLAP + BLANK);
    localparam logic [5:0]       OVR_LIM   = 6'(OVR_LIMIT);

    logic [1:0] ovr_i;
    logic [1:0] ovr_vld;
    logic       any_flag;
    logic [1:0] flag_q, flag_d;
    logic [5:0] ovr_cnt_q, ovr_cnt_d;
    logic       shtdwn_q;

    assign ovr_i = {OVR_I_rght, OVR_I_lft};

    // Qualify comparator samples after blanking, flag bad periods and count them.
    always_comb begin
        ovr_vld   = '0;
        ovr_cnt_d = ovr_cnt_q;
        for (int s = 0; s < 2; s++) begin
            // The comparator reads garbage while the bridge current settles
            // after a high-side turn-on, so it is trusted only past the blank window.
            ovr_vld[s] = ovr_i[s] & pwm1_q[s] & (run_q[s] > BLANK_THR);
        end
        flag_d   = flag_q | ovr_vld;
        any_flag = |flag_d;
        if (cnt_q == CNT_LAST) begin
            // The count tracks consecutive bad periods. One clean period resets it.
            if (any_flag) begin
                if (ovr_cnt_q != 6'h3F) begin
                    ovr_cnt_d = ovr_cnt_q + 6'd1;
                end
            end else begin
                ovr_cnt_d = '0;
            end
            flag_d = '0;
        end
        shtdwn_d = shtdwn_q | (ovr_cnt_q == OVR_LIM);
    end

    // Overcurrent state. The shutdown latch is released only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_q    <= '0;
            ovr_cnt_q <= '0;
            shtdwn_q  <= 1'b0;
        end else begin
            flag_q    <= flag_d;
            ovr_cnt_q <= ovr_cnt_d;
            shtdwn_q  <= shtdwn_d;
        end
    end

    assign OVR_I_shtdwn = shtdwn_q;
`else
    localparam int unused_ovr_limit = OVR_LIMIT;
    logic unused_ovr_i;

    assign unused_ovr_i = OVR_I_lft | OVR_I_rght;
    assign shtdwn_d     = 1'b0;
    assign OVR_I_shtdwn = 1'b0;
`endif

    assign PWM1_lft  = pwm1_q[0];
    assign PWM2_lft  = pwm2_q[0];
    assign PWM1_rght = pwm1_q[1];
    assign PWM2_rght = pwm2_q[1];

endmodule
